// File: rtl/fetch_stall_unit.sv
// Fetch-side stall/flush consumer: PC, IF/ID and ID/EX control registers plus a stall watchdog FSM.
// Optional PIPE_PERF_EN macro builds the saturating stall/flush performance counters.
module fetch_stall_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          PC_STEP     = 4,
    parameter int          CTRL_W      = 10,
    parameter int          STALL_LIMIT = 8,
    parameter int          CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PC_write,
    input  logic              IFID_write,
    input  logic              IF_flush,
    input  logic              stall_IDEX,
    input  logic              BranchAND,
    input  logic              Jump,
    input  logic              JumpRegister,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       JumpTarget,
    input  logic [31:0]       JumpRegTarget,
    input  logic [31:0]       Instr_IF,
    input  logic [CTRL_W-1:0] Ctrl_DEC,
    output logic [31:0]       PC_out,
    output logic [31:0]       Instr_ID,
    output logic [31:0]       PCPlus4_ID,
    output logic [CTRL_W-1:0] Ctrl_EX,
    output logic [1:0]        State,
    output logic              Deadlock,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int          RUN_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [31:0] STEP    = 32'(PC_STEP);
    localparam logic [RUN_W-1:0] LIMIT_V = RUN_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_STALL    = 2'd1,
        S_REDIRECT = 2'd2,
        S_HUNG     = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [RUN_W-1:0] run_cnt, run_next;
    logic             deadlock_next;
    logic [31:0]      pc_plus, pc_next;

    assign pc_plus = PC_out + STEP;

    // Redirect priority: jr over j/jal over taken branch over sequential.
    always_comb begin
        pc_next = PC_out;
        if (PC_write) begin
            if (JumpRegister)   pc_next = JumpRegTarget;
            else if (Jump)      pc_next = JumpTarget;
            else if (BranchAND) pc_next = BranchTarget;
            else                pc_next = pc_plus;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PC_out     <= PC_RESET;
            Instr_ID   <= 32'h0;
            PCPlus4_ID <= 32'h0;
            Ctrl_EX    <= '0;
        end else begin
            PC_out <= pc_next;
            if (IF_flush) begin
                Instr_ID   <= 32'h0;
                PCPlus4_ID <= 32'h0;
            end else if (IFID_write) begin
                Instr_ID   <= Instr_IF;
                PCPlus4_ID <= pc_plus;
            end
            Ctrl_EX <= stall_IDEX ? '0 : Ctrl_DEC;
        end
    end

    // Stall outranks flush in every state; HUNG only leaves through reset.
    always_comb begin
        state_next    = state;
        run_next      = stall_IDEX ? run_cnt : '0;
        deadlock_next = Deadlock;
        case (state)
            S_RUN, S_REDIRECT: begin
                if (stall_IDEX) begin
                    state_next = S_STALL;
                    run_next   = RUN_W'(1);
                end else if (IF_flush) begin
                    state_next = S_REDIRECT;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_STALL: begin
                if (stall_IDEX) begin
                    run_next = run_cnt + RUN_W'(1);
                    if (run_cnt + RUN_W'(1) >= LIMIT_V) begin
                        state_next    = S_HUNG;
                        deadlock_next = 1'b1;
                    end
                end else if (IF_flush) begin
                    state_next = S_REDIRECT;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_HUNG: begin
                state_next    = S_HUNG;
                deadlock_next = 1'b1;
            end
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= S_RUN;
            run_cnt  <= '0;
            Deadlock <= 1'b0;
        end else begin
            state    <= state_next;
            run_cnt  <= run_next;
            Deadlock <= deadlock_next;
        end
    end

    assign State = state;

`ifdef PIPE_PERF_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_IDEX && (StallCount != '1)) StallCount <= StallCount + 1'b1;
            if (IF_flush && (FlushCount != '1))   FlushCount <= FlushCount + 1'b1;
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Bench for fetch_stall_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_fetch_stall_unit;

    localparam int CTRL_W = 10;
    localparam int LIMIT  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pc_write = 0, ifid_write = 0, if_flush = 0, stall_idex = 0;
    logic              branch_and = 0, jump = 0, jump_reg = 0;
    logic [31:0]       branch_target = 0, jump_target = 0, jump_reg_target = 0, instr_if = 0;
    logic [CTRL_W-1:0] ctrl_dec = 0;

    logic [31:0]       pc_out, instr_id, pcplus4_id;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [1:0]        state;
    logic              deadlock;
    logic [CNT_W-1:0]  stall_count, flush_count;

    logic [31:0]       w_pc_out, w_instr_id, w_pcplus4_id;
    logic [CTRL_W-1:0] w_ctrl_ex;
    logic [1:0]        w_state;
    logic              w_deadlock;
    logic [CNT_W-1:0]  w_stall_count, w_flush_count;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    fetch_stall_unit #(.PC_RESET(32'h0), .PC_STEP(4), .CTRL_W(CTRL_W),
                       .STALL_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .Clk(clk), .Rst(rst), .PC_write(pc_write), .IFID_write(ifid_write),
        .IF_flush(if_flush), .stall_IDEX(stall_idex), .BranchAND(branch_and),
        .Jump(jump), .JumpRegister(jump_reg), .BranchTarget(branch_target),
        .JumpTarget(jump_target), .JumpRegTarget(jump_reg_target), .Instr_IF(instr_if),
        .Ctrl_DEC(ctrl_dec), .PC_out(pc_out), .Instr_ID(instr_id), .PCPlus4_ID(pcplus4_id),
        .Ctrl_EX(ctrl_ex), .State(state), .Deadlock(deadlock),
        .StallCount(stall_count), .FlushCount(flush_count));

    // Second instance exercises the 32-bit PC wrap from a top-of-memory reset vector.
    fetch_stall_unit #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(4), .CTRL_W(CTRL_W),
                       .STALL_LIMIT(LIMIT), .CNT_W(CNT_W)) u_wrap (
        .Clk(clk), .Rst(rst), .PC_write(pc_write), .IFID_write(ifid_write),
        .IF_flush(if_flush), .stall_IDEX(stall_idex), .BranchAND(branch_and),
        .Jump(jump), .JumpRegister(jump_reg), .BranchTarget(branch_target),
        .JumpTarget(jump_target), .JumpRegTarget(jump_reg_target), .Instr_IF(instr_if),
        .Ctrl_DEC(ctrl_dec), .PC_out(w_pc_out), .Instr_ID(w_instr_id), .PCPlus4_ID(w_pcplus4_id),
        .Ctrl_EX(w_ctrl_ex), .State(w_state), .Deadlock(w_deadlock),
        .StallCount(w_stall_count), .FlushCount(w_flush_count));

    // behavioural model: state is a function of last cycle's requests plus a sticky hang flag
    logic [31:0]       m_pc, m_instr, m_pcp4;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_run;
    bit                m_hung, m_last_stall, m_last_flush;
    int                m_scnt, m_fcnt;

    function automatic int exp_state();
        if (m_hung)       return 3;
        if (m_last_stall) return 1;
        if (m_last_flush) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_ctrl = '0;
        m_run = 0; m_hung = 0; m_last_stall = 0; m_last_flush = 0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (if_flush) begin
            m_instr = 32'h0; m_pcp4 = 32'h0;
        end else if (ifid_write) begin
            m_instr = instr_if; m_pcp4 = seq;
        end
        if (pc_write)
            m_pc = jump_reg ? jump_reg_target : jump ? jump_target : branch_and ? branch_target : seq;
        m_ctrl = stall_idex ? '0 : ctrl_dec;
        m_run = stall_idex ? m_run + 1 : 0;
        if (m_run >= LIMIT) m_hung = 1;
        m_last_stall = stall_idex;
        m_last_flush = if_flush;
`ifdef PIPE_PERF_EN
        if (stall_idex && m_scnt < (1 << CNT_W) - 1) m_scnt++;
        if (if_flush && m_fcnt < (1 << CNT_W) - 1)   m_fcnt++;
`endif
    endtask

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("pc_out",      pc_out,                m_pc);
        check("instr_id",    instr_id,              m_instr);
        check("pcplus4_id",  pcplus4_id,            m_pcp4);
        check("ctrl_ex",     32'(ctrl_ex),          32'(m_ctrl));
        check("state",       32'(state),            32'(exp_state()));
        check("deadlock",    32'(deadlock),         32'(m_hung));
        check("stall_count", 32'(stall_count),      32'(m_scnt));
        check("flush_count", 32'(flush_count),      32'(m_fcnt));
    endtask

    // driver tasks: inputs change at negedge, model advances at posedge, compare at next negedge
    task automatic clear_inputs();
        pc_write = 0; ifid_write = 0; if_flush = 0; stall_idex = 0;
        branch_and = 0; jump = 0; jump_reg = 0;
        branch_target = 0; jump_target = 0; jump_reg_target = 0;
        instr_if = $urandom(); ctrl_dec = CTRL_W'($urandom());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
        rst = 1'b0;
    endtask

    task automatic random_inputs(input int stall_pct);
        pc_write        = ($urandom_range(0, 99) < 70);
        ifid_write      = ($urandom_range(0, 99) < 70);
        if_flush        = ($urandom_range(0, 99) < 15);
        stall_idex      = ($urandom_range(0, 99) < stall_pct);
        branch_and      = ($urandom_range(0, 99) < 20);
        jump            = ($urandom_range(0, 99) < 15);
        jump_reg        = ($urandom_range(0, 99) < 10);
        branch_target   = $urandom() & 32'hFFFF_FFFC;
        jump_target     = $urandom() & 32'hFFFF_FFFC;
        jump_reg_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        instr_if        = $urandom();
        ctrl_dec        = CTRL_W'($urandom());
    endtask

    initial begin
        int stall_pct;
        clear_inputs();
        @(negedge clk);
        do_reset();
        check("rst_pc_lit",    pc_out,          32'h0);
        check("rst_state_lit", 32'(state),      32'd0);
        check("rst_dead_lit",  32'(deadlock),   32'd0);
        check("rst_ctrl_lit",  32'(ctrl_ex),    32'd0);
        check("rst_wrap_lit",  w_pc_out,        32'hFFFF_FFFC);

        // three sequential fetches
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            pc_write = 1; ifid_write = 1; instr_if = 32'hA000_0000 + 32'(i);
            step();
            check("seq_pc_lit",    pc_out,   32'(4 * (i + 1)));
            check("seq_instr_lit", instr_id, 32'hA000_0000 + 32'(i));
            if (i == 0) check("wrap_pc_lit", w_pc_out, 32'h0);
        end

        // move to 0x40, then stall two cycles
        clear_inputs();
        pc_write = 1; ifid_write = 1; jump = 1; jump_target = 32'h40; instr_if = 32'h1234_5678;
        step();
        check("jmp40_lit", pc_out, 32'h40);
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            stall_idex = 1;
            step();
        end
        check("stall_pc_lit",    pc_out,          32'h40);
        check("stall_instr_lit", instr_id,        32'h1234_5678);
        check("stall_ctrl_lit",  32'(ctrl_ex),    32'd0);
        check("stall_state_lit", 32'(state),      32'd1);
`ifdef PIPE_PERF_EN
        check("stall_cnt_lit",   32'(stall_count), 32'd2);
`else
        check("stall_cnt_lit",   32'(stall_count), 32'd0);
`endif

        // jump with flush
        clear_inputs();
        pc_write = 1; ifid_write = 1; if_flush = 1; jump = 1; jump_target = 32'h100;
        step();
        check("redir_pc_lit",    pc_out,     32'h100);
        check("redir_instr_lit", instr_id,   32'h0);
        check("redir_state_lit", 32'(state), 32'd2);
        clear_inputs();
        step();
        check("redir_run_lit", 32'(state), 32'd0);

        // jr beats branch
        clear_inputs();
        pc_write = 1; jump_reg = 1; branch_and = 1;
        jump_reg_target = 32'h200; branch_target = 32'h300;
        step();
        check("jr_prio_lit", pc_out, 32'h200);

        // watchdog
        for (int i = 1; i <= LIMIT; i++) begin
            clear_inputs();
            stall_idex = 1;
            step();
            if (i == LIMIT - 1) check("pre_hung_lit", 32'(state), 32'd1);
        end
        check("hung_state_lit", 32'(state),    32'd3);
        check("hung_dead_lit",  32'(deadlock), 32'd1);
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            pc_write = 1;
            step();
        end
        check("hung_hold_lit", 32'(state), 32'd3);
        do_reset();
        check("hung_clr_lit", 32'(deadlock), 32'd0);

        // randomized traffic with stall-heavy bursts and occasional async resets
        stall_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) stall_pct = ($urandom_range(0, 3) == 0) ? 95 : 30;
            random_inputs(stall_pct);
            step();
            if ($urandom_range(0, 249) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
